// File: rtl/bin_to_decimal_pkg.sv
// Shared types and constants for the binary-to-BCD display path.
// Digit sizing helper lets the conversion array scale with the input width.
package bin_to_decimal_pkg;

    localparam int DIGIT_W         = 4;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam int DEFAULT_MAX_VAL = 99;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    // Number of BCD nibbles needed for the largest w-bit value, never fewer than three.
    function automatic int bcd_digits(input int w);
        int v;
        int n;
        v = (1 << w) - 1;
        n = 0;
        while (v > 0) begin
            v = v / 10;
            n = n + 1;
        end
        if (n < 3) n = 3;
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Single-nibble double-dabble adjust cell: adds 3 when the digit is 5 or more.
// Purely combinational; no latency, no backpressure.
module bcd_add3
    import bin_to_decimal_pkg::*;
(
    input  bcd_digit_t in_i,
    output bcd_digit_t out_o
);

    assign out_o = (in_i >= 4'd5) ? bcd_digit_t'(in_i + 4'd3) : in_i;

endmodule

// File: rtl/bin_to_decimal.sv
// Saturating binary to two-digit BCD converter for the scoreboard display.
// One-cycle latency, accepts a new value every cycle, no handshake.
module bin_to_decimal
    import bin_to_decimal_pkg::*;
#(
    parameter int BIN_W   = 8,
    parameter int MAX_VAL = DEFAULT_MAX_VAL
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic [3:0]       tens_o,
    output logic [3:0]       ones_o
);

    localparam int NDIG      = bcd_digits(BIN_W);
    localparam int SW        = NDIG * DIGIT_W + BIN_W;
    localparam int MAX_REPR  = (1 << BIN_W) - 1;
    localparam int MAX_CLAMP = (MAX_VAL > MAX_REPR) ? MAX_REPR : MAX_VAL;
    localparam logic [BIN_W-1:0] MAX_B = MAX_CLAMP[BIN_W-1:0];

    logic [BIN_W-1:0]          sat_val;
    logic [BIN_W:0][SW-1:0]    stg;
    logic [BIN_W-1:0][SW-1:0]  adj;
    logic [BIN_W-1:0]          drop_unused;
    logic [NDIG*DIGIT_W-1:0]   bcd_res;
    logic                      unused_ok;

    bcd_digit_t tens_d, tens_q;
    bcd_digit_t ones_d, ones_q;

    // Clamping before conversion keeps every produced digit inside 0..9.
    assign sat_val = (bin_i > MAX_B) ? MAX_B : bin_i;
    assign stg[0]  = {{(NDIG*DIGIT_W){1'b0}}, sat_val};

    for (genvar i = 0; i < BIN_W; i++) begin : g_iter
        assign adj[i][BIN_W-1:0] = stg[i][BIN_W-1:0];
        for (genvar d = 0; d < NDIG; d++) begin : g_dig
            bcd_add3 u_add3 (
                .in_i  (stg[i][BIN_W+DIGIT_W*d +: DIGIT_W]),
                .out_o (adj[i][BIN_W+DIGIT_W*d +: DIGIT_W])
            );
        end
        assign stg[i+1]       = {adj[i][SW-2:0], 1'b0};
        assign drop_unused[i] = adj[i][SW-1];
    end

    assign bcd_res = stg[BIN_W][SW-1:BIN_W];
    assign tens_d  = bcd_res[7:4];
    assign ones_d  = bcd_res[3:0];

    // Upper nibbles stay zero after saturation; shifted-out bits carry nothing.
    assign unused_ok = ^{drop_unused, stg[BIN_W][BIN_W-1:0], bcd_res[NDIG*DIGIT_W-1:8]};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tens_q <= '0;
            ones_q <= '0;
        end else begin
            tens_q <= tens_d;
            ones_q <= ones_d;
        end
    end

    assign tens_o = tens_q;
    assign ones_o = ones_q;

endmodule

// File: tb/tb_bin_to_decimal.sv
// Directed bench for bin_to_decimal: reset, conversion, rollover, saturation, sweep.
module tb_bin_to_decimal;

    logic       clk;
    logic       rst_n;
    logic [7:0] bin;
    logic [3:0] tens;
    logic [3:0] ones;

    int checks;
    int failures;

    bin_to_decimal #(.BIN_W(8), .MAX_VAL(99)) dut (
        .clk_i  (clk),
        .rst_i  (rst_n),
        .bin_i  (bin),
        .tens_o (tens),
        .ones_o (ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic [7:0] v, input logic [3:0] et, input logic [3:0] eo,
                         input string name);
        @(negedge clk);
        bin = v;
        @(posedge clk);
        #1;
        checks++;
        if (tens !== et || ones !== eo) begin
            failures++;
            $display("FAIL %s bin=%0d got=%0d/%0d expected=%0d/%0d", name, v, tens, ones, et, eo);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bin   = 8'd42;
        #1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (tens !== 4'd0 || ones !== 4'd0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got=%0d/%0d expected=0/0", i, tens, ones);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        apply(8'd0,  4'd0, 4'd0, "basic_0");
        apply(8'd5,  4'd0, 4'd5, "basic_5");
        apply(8'd15, 4'd1, 4'd5, "basic_15");
        apply(8'd42, 4'd4, 4'd2, "basic_42");
    endtask

    task automatic test_rollover();
        apply(8'd73, 4'd7, 4'd3, "roll_73");
        apply(8'd99, 4'd9, 4'd9, "roll_99");
        apply(8'd9,  4'd0, 4'd9, "roll_9");
        apply(8'd10, 4'd1, 4'd0, "roll_10");
    endtask

    task automatic test_saturation();
        apply(8'd100, 4'd9, 4'd9, "sat_100");
        apply(8'd128, 4'd9, 4'd9, "sat_128");
        apply(8'd200, 4'd9, 4'd9, "sat_200");
        apply(8'd255, 4'd9, 4'd9, "sat_255");
    endtask

    task automatic test_reset_mid();
        apply(8'd42, 4'd4, 4'd2, "mid_pre");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tens !== 4'd0 || ones !== 4'd0) begin
            failures++;
            $display("FAIL mid_async_clear got=%0d/%0d expected=0/0", tens, ones);
        end
        bin = 8'd99;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (tens !== 4'd0 || ones !== 4'd0) begin
                failures++;
                $display("FAIL mid_hold cyc=%0d got=%0d/%0d expected=0/0", i, tens, ones);
            end
        end
        @(negedge clk);
        bin   = 8'd73;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (tens !== 4'd7 || ones !== 4'd3) begin
            failures++;
            $display("FAIL mid_release got=%0d/%0d expected=7/3", tens, ones);
        end
    endtask

    task automatic test_sweep();
        int e;
        for (int v = 0; v < 256; v++) begin
            e = (v > 99) ? 99 : v;
            @(negedge clk);
            bin = 8'(v);
            @(posedge clk);
            #1;
            checks++;
            if (tens !== 4'(e / 10) || ones !== 4'(e % 10) || tens > 4'd9 || ones > 4'd9) begin
                failures++;
                $display("FAIL sweep bin=%0d got=%0d/%0d expected=%0d/%0d", v, tens, ones,
                         e / 10, e % 10);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_rollover();
        test_saturation();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
